// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN pooling blocks: compare-mode encoding
// and the helper that locates a lane inside a packed multi-lane bus.
package cnn_pkg;

   localparam int MAX_UNSIGNED = 0;
   localparam int MAX_SIGNED   = 1;

   function automatic int lane_lsb(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/max_lane.sv
// One lane of the max-pool accumulator: running-max register with a
// direct load on the first sample of a window and a compare afterwards.
module max_lane
   import cnn_pkg::*;
#(
   parameter int N      = 8,
   parameter int SIGNED = MAX_UNSIGNED
) (
   input  logic         clk,
   input  logic         master_rst,
   input  logic         clear,
   input  logic         load,
   input  logic         update,
   input  logic [N-1:0] din,
   output logic [N-1:0] run_next
);

   logic [N-1:0] run_q;
   logic [N-1:0] run_d;
   logic         din_gt;

   always_comb begin
      if (SIGNED == MAX_SIGNED) begin
         din_gt = $signed(din) > $signed(run_q);
      end else begin
         din_gt = din > run_q;
      end
   end

   // Ties keep the stored value; a cleared window is zeroed so it cannot leak.
   always_comb begin
      run_d = run_q;
      if (clear) begin
         run_d = '0;
      end else if (load) begin
         run_d = din;
      end else if (update && din_gt) begin
         run_d = din;
      end
   end

   always_ff @(posedge clk) begin
      if (master_rst) begin
         run_q <= '0;
      end else begin
         run_q <= run_d;
      end
   end

   assign run_next = run_d;

endmodule

// File: rtl/maxpool_acc.sv
// Multi-lane max-pool accumulator: tracks the per-lane maximum over windows
// of K samples and presents each completed window's result for one cycle.
module maxpool_acc
   import cnn_pkg::*;
#(
   parameter int N      = 8,
   parameter int C      = 4,
   parameter int K      = 4,
   parameter int SIGNED = MAX_UNSIGNED
) (
   input  logic                 clk,
   input  logic                 master_rst,
   input  logic                 ce,
   input  logic                 clr,
   input  logic                 in_valid,
   input  logic [C*N-1:0]       din,
   output logic [C*N-1:0]       dout,
   output logic                 out_valid,
   output logic [$clog2(K)-1:0] cnt
);

   localparam int            CW       = $clog2(K);
   localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);

   logic [CW-1:0]  cnt_q, cnt_d;
   logic [C*N-1:0] dout_q, dout_d;
   logic           out_valid_q, out_valid_d;
   logic [C*N-1:0] run_next_all;
   logic           accept, clear, first, last;

   assign clear  = ce && clr;
   assign accept = ce && in_valid && !clr;
   assign first  = (cnt_q == '0);
   assign last   = (cnt_q == CNT_LAST);

   for (genvar g = 0; g < C; g++) begin : g_lane
      max_lane #(
         .N      (N),
         .SIGNED (SIGNED)
      ) u_lane (
         .clk        (clk),
         .master_rst (master_rst),
         .clear      (clear),
         .load       (accept && first),
         .update     (accept && !first),
         .din        (din[lane_lsb(g, N) +: N]),
         .run_next   (run_next_all[lane_lsb(g, N) +: N])
      );
   end

   // The K-th sample both closes the window and captures its final maxima.
   always_comb begin
      cnt_d       = cnt_q;
      dout_d      = dout_q;
      out_valid_d = 1'b0;
      if (clear) begin
         cnt_d = '0;
      end else if (accept) begin
         if (last) begin
            cnt_d       = '0;
            dout_d      = run_next_all;
            out_valid_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (master_rst) begin
         cnt_q       <= '0;
         dout_q      <= '0;
         out_valid_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         dout_q      <= dout_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign cnt       = cnt_q;
   assign dout      = dout_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_maxpool_acc.sv
// Self-checking bench for maxpool_acc: unsigned and signed instances share
// stimulus and are compared against a window-list reference model.
module tb_maxpool_acc;

   localparam int N = 8;
   localparam int C = 4;
   localparam int K = 4;

   logic          clk = 1'b0;
   logic          master_rst, ce, clr, in_valid;
   logic [C*N-1:0] din;
   logic [C*N-1:0] dout_u, dout_s;
   logic          ov_u, ov_s;
   logic [1:0]    cnt_u, cnt_s;

   int checks   = 0;
   int failures = 0;
   int pulses   = 0;

   logic [C*N-1:0] win_q[$];
   logic [C*N-1:0] exp_dout_u = '0;
   logic [C*N-1:0] exp_dout_s = '0;
   logic           exp_ov     = 1'b0;

   always #5 clk = ~clk;

   maxpool_acc #(.N(N), .C(C), .K(K), .SIGNED(0)) dut_u (
      .clk(clk), .master_rst(master_rst), .ce(ce), .clr(clr), .in_valid(in_valid),
      .din(din), .dout(dout_u), .out_valid(ov_u), .cnt(cnt_u)
   );

   maxpool_acc #(.N(N), .C(C), .K(K), .SIGNED(1)) dut_s (
      .clk(clk), .master_rst(master_rst), .ce(ce), .clr(clr), .in_valid(in_valid),
      .din(din), .dout(dout_s), .out_valid(ov_s), .cnt(cnt_s)
   );

   // Per-lane maximum over every sample held in the current window.
   function automatic logic [C*N-1:0] window_max(input bit signed_cmp);
      logic [C*N-1:0] r;
      logic [N-1:0]   b;
      int             best, v;
      r = '0;
      for (int c = 0; c < C; c++) begin
         best = -100000;
         foreach (win_q[i]) begin
            b = win_q[i][c*N +: N];
            v = signed_cmp ? int'($signed(b)) : int'(b);
            if (v > best) best = v;
         end
         r[c*N +: N] = best[N-1:0];
      end
      return r;
   endfunction

   task automatic cycle(input logic rst, input logic ce_i, input logic clr_i,
                        input logic iv, input logic [C*N-1:0] d);
      master_rst = rst;
      ce         = ce_i;
      clr        = clr_i;
      in_valid   = iv;
      din        = d;
      @(posedge clk);
      #1;
      exp_ov = 1'b0;
      if (rst) begin
         win_q.delete();
         exp_dout_u = '0;
         exp_dout_s = '0;
      end else if (ce_i && clr_i) begin
         win_q.delete();
      end else if (ce_i && iv) begin
         win_q.push_back(d);
         if (win_q.size() == K) begin
            exp_dout_u = window_max(1'b0);
            exp_dout_s = window_max(1'b1);
            exp_ov     = 1'b1;
            win_q.delete();
         end
      end
      if (ov_u) pulses++;
   endtask

   task automatic test_reset();
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
      checks++;
      if (cnt_u !== 2'd0 || cnt_s !== 2'd0) begin
         failures++;
         $display("FAIL reset_cnt got=%0d/%0d exp=0", cnt_u, cnt_s);
      end
      checks++;
      if (dout_u !== '0 || dout_s !== '0) begin
         failures++;
         $display("FAIL reset_dout got=%h/%h exp=0", dout_u, dout_s);
      end
      checks++;
      if (ov_u !== 1'b0 || ov_s !== 1'b0) begin
         failures++;
         $display("FAIL reset_ov got=%b/%b exp=0", ov_u, ov_s);
      end
   endtask

   task automatic test_basic();
      logic [7:0] seq[4];
      seq = '{8'd3, 8'd9, 8'd2, 8'd7};
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 1'b1, {$urandom_range(0, 16'hFFFF), $urandom_range(0, 255), seq[i]});
         checks++;
         if (cnt_u !== 2'((i + 1) % K) || ov_u !== exp_ov) begin
            failures++;
            $display("FAIL basic_step%0d cnt=%0d ov=%b exp cnt=%0d ov=%b", i, cnt_u, ov_u, (i + 1) % K, exp_ov);
         end
      end
      checks++;
      if (ov_u !== 1'b1 || dout_u[7:0] !== 8'd9) begin
         failures++;
         $display("FAIL basic_result ov=%b lane0=%0d exp ov=1 lane0=9", ov_u, dout_u[7:0]);
      end
      checks++;
      if (dout_u !== exp_dout_u) begin
         failures++;
         $display("FAIL basic_all_lanes got=%h exp=%h", dout_u, exp_dout_u);
      end
      cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
      checks++;
      if (ov_u !== 1'b0 || dout_u[7:0] !== 8'd9) begin
         failures++;
         $display("FAIL basic_after ov=%b lane0=%0d exp ov=0 lane0=9", ov_u, dout_u[7:0]);
      end
   endtask

   task automatic test_signed();
      logic [7:0] seq[4];
      seq = '{8'h80, 8'hFF, 8'h05, 8'h7F};
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 1'b1, {24'h0, seq[i]} | ($urandom() & 32'hFFFF_FF00));
      end
      checks++;
      if (dout_s[7:0] !== 8'h7F || ov_s !== 1'b1) begin
         failures++;
         $display("FAIL signed_lane0 got=%h ov=%b exp=7f ov=1", dout_s[7:0], ov_s);
      end
      checks++;
      if (dout_u[7:0] !== 8'hFF) begin
         failures++;
         $display("FAIL unsigned_lane0 got=%h exp=ff", dout_u[7:0]);
      end
      checks++;
      if (dout_s !== exp_dout_s || dout_u !== exp_dout_u) begin
         failures++;
         $display("FAIL signed_all_lanes got=%h/%h exp=%h/%h", dout_s, dout_u, exp_dout_s, exp_dout_u);
      end
   endtask

   task automatic test_back_to_back();
      pulses = 0;
      for (int v = 1; v <= 8; v++) begin
         cycle(1'b0, 1'b1, 1'b0, 1'b1, {4{8'(v)}});
         checks++;
         if (ov_u !== ((v % 4) == 0)) begin
            failures++;
            $display("FAIL b2b_ov_cycle%0d got=%b exp=%b", v + 1, ov_u, (v % 4) == 0);
         end
         if (v == 4 || v == 8) begin
            checks++;
            if (dout_u !== {4{8'(v)}}) begin
               failures++;
               $display("FAIL b2b_dout_cycle%0d got=%h exp=%h", v + 1, dout_u, {4{8'(v)}});
            end
         end
      end
      cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
      checks++;
      if (pulses != 2 || ov_u !== 1'b0) begin
         failures++;
         $display("FAIL b2b_pulses got=%0d ov=%b exp=2 ov=0", pulses, ov_u);
      end
   endtask

   task automatic test_ce_freeze();
      pulses = 0;
      cycle(1'b0, 1'b1, 1'b0, 1'b1, {4{8'd10}});
      cycle(1'b0, 1'b1, 1'b0, 1'b1, {4{8'd20}});
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b0, (i == 1), 1'b1, $urandom());
         checks++;
         if (cnt_u !== 2'd2 || ov_u !== 1'b0) begin
            failures++;
            $display("FAIL ce_freeze_%0d cnt=%0d ov=%b exp cnt=2 ov=0", i, cnt_u, ov_u);
         end
      end
      cycle(1'b0, 1'b1, 1'b0, 1'b1, {4{8'd5}});
      cycle(1'b0, 1'b1, 1'b0, 1'b1, {4{8'd1}});
      checks++;
      if (pulses != 1 || dout_u[7:0] !== 8'd20 || dout_u !== exp_dout_u) begin
         failures++;
         $display("FAIL ce_result pulses=%0d dout=%h exp pulses=1 dout=%h", pulses, dout_u, exp_dout_u);
      end
   endtask

   task automatic test_clr();
      logic [C*N-1:0] held;
      pulses = 0;
      held   = dout_u;
      cycle(1'b0, 1'b1, 1'b0, 1'b1, {4{8'd50}});
      cycle(1'b0, 1'b1, 1'b0, 1'b1, {4{8'd60}});
      cycle(1'b0, 1'b1, 1'b1, 1'b1, {4{8'd99}});
      checks++;
      if (cnt_u !== 2'd0 || ov_u !== 1'b0 || dout_u !== held) begin
         failures++;
         $display("FAIL clr_abort cnt=%0d ov=%b dout=%h exp cnt=0 ov=0 dout=%h", cnt_u, ov_u, dout_u, held);
      end
      for (int v = 1; v <= 4; v++) cycle(1'b0, 1'b1, 1'b0, 1'b1, {4{8'(v)}});
      checks++;
      if (pulses != 1 || dout_u !== {4{8'd4}}) begin
         failures++;
         $display("FAIL clr_result pulses=%0d dout=%h exp pulses=1 dout=04040404", pulses, dout_u);
      end
   endtask

   task automatic test_reset_mid();
      pulses = 0;
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1, $urandom());
      cycle(1'b1, 1'b1, 1'b0, 1'b1, $urandom());
      checks++;
      if (cnt_u !== 2'd0 || dout_u !== '0 || dout_s !== '0 || ov_u !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid cnt=%0d dout=%h ov=%b exp cnt=0 dout=0 ov=0", cnt_u, dout_u, ov_u);
      end
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1, $urandom());
      checks++;
      if (pulses != 1 || ov_u !== 1'b1 || dout_u !== exp_dout_u || dout_s !== exp_dout_s) begin
         failures++;
         $display("FAIL rst_fresh pulses=%0d dout=%h/%h exp=%h/%h", pulses, dout_u, dout_s, exp_dout_u, exp_dout_s);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 11) == 0), ($urandom_range(0, 3) != 0), $urandom());
         checks++;
         if (ov_u !== exp_ov || ov_s !== exp_ov || cnt_u !== 2'(win_q.size())
             || cnt_s !== 2'(win_q.size()) || dout_u !== exp_dout_u || dout_s !== exp_dout_s) begin
            failures++;
            $display("FAIL random_%0d ov=%b/%b cnt=%0d/%0d dout=%h/%h exp ov=%b cnt=%0d dout=%h/%h",
                     i, ov_u, ov_s, cnt_u, cnt_s, dout_u, dout_s, exp_ov, win_q.size(), exp_dout_u, exp_dout_s);
         end
      end
   endtask

   initial begin
      master_rst = 1'b1;
      ce         = 1'b0;
      clr        = 1'b0;
      in_valid   = 1'b0;
      din        = '0;
      test_reset();
      test_basic();
      test_signed();
      test_back_to_back();
      test_ce_freeze();
      test_clr();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
